// File: rtl/pipe_pkg.sv
// Shared types for the skid pipeline stage register.
// State encoding and occupancy codes.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      BUSY,
      FULL
   } skid_state_t;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_BUSY  = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_register_ctrl.sv
// Control FSM for the skid stage register.
// Decodes handshake outputs and datapath load enables.
module skid_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       out_ready,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] occupancy,
   output logic       load_main,
   output logic       sel_skid,
   output logic       load_skid
);

   skid_state_t state_q;
   skid_state_t state_d;
   logic        in_fire;
   logic        out_fire;

   // Outputs decode from registered state only.
   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
      occupancy = OCC_EMPTY;
      case (state_q)
         BUSY:    occupancy = OCC_BUSY;
         FULL:    occupancy = OCC_FULL;
         default: occupancy = OCC_EMPTY;
      endcase
   end

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Next state and load enables; flush wins over any fire.
   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      sel_skid  = 1'b0;
      load_skid = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d   = BUSY;
                  load_main = 1'b1;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  state_d   = FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d   = BUSY;
                  load_main = 1'b1;
                  sel_skid  = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
   end

endmodule

// File: rtl/pipe_skid_register.sv
// Pipeline stage register with one skid entry,
// registered in_ready, flush and a stall counter.
module pipe_skid_register
   import pipe_pkg::*;
#(
   parameter int               WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_count
);

   logic                   load_main;
   logic                   sel_skid;
   logic                   load_skid;
   logic [WIDTH-1:0]       main_q;
   logic [WIDTH-1:0]       main_d;
   logic [WIDTH-1:0]       skid_q;
   logic [WIDTH-1:0]       skid_d;
   logic [STALL_CNT_W-1:0] stall_q;
   logic [STALL_CNT_W-1:0] stall_d;

   skid_ctrl u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .occupancy (occupancy),
      .load_main (load_main),
      .sel_skid  (sel_skid),
      .load_skid (load_skid)
   );

   // Datapath next values; main refills from skid when draining FULL.
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (flush) begin
         main_d = RESET_VALUE;
         skid_d = RESET_VALUE;
      end else begin
         if (load_main) main_d = sel_skid ? skid_q : in_data;
         if (load_skid) skid_d = in_data;
      end
   end

   // Saturating stall count; flush leaves it alone.
   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != '1))
         stall_d = stall_q + 1'b1;
   end

   // Datapath and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
         stall_q <= '0;
      end else begin
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

   assign out_data    = main_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_skid_register.sv
// Directed bench for pipe_skid_register.
// Second instance uses a 3-bit stall counter for saturation.
module tb_pipe_skid_register;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_count;
   logic        s_in_ready;
   logic        s_out_valid;
   logic [63:0] s_out_data;
   logic [1:0]  s_occupancy;
   logic [2:0]  s_stall_count;

   int n_chk  = 0;
   int n_pass = 0;

   pipe_skid_register u_dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .occupancy   (occupancy),
      .stall_count (stall_count)
   );

   pipe_skid_register #(.STALL_CNT_W(3)) u_sat (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (s_in_ready),
      .in_data     (in_data),
      .out_valid   (s_out_valid),
      .out_ready   (out_ready),
      .out_data    (s_out_data),
      .occupancy   (s_occupancy),
      .stall_count (s_stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hDEAD;
      out_ready = 1'b0;

      repeat (2) step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_occ", {62'd0, occupancy}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_stall", {48'd0, stall_count}, 64'd0);

      reset    = 1'b1;
      in_valid = 1'b0;
      step();

      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'h1;
      step();
      chk("str1_data", out_data, 64'h1);
      chk("str1_valid", {63'd0, out_valid}, 64'd1);
      in_data = 64'h2;
      step();
      chk("str2_data", out_data, 64'h2);
      chk("str2_occ", {62'd0, occupancy}, 64'd1);
      in_data = 64'h3;
      step();
      chk("str3_data", out_data, 64'h3);
      chk("str3_in_ready", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      step();
      chk("str_drain_valid", {63'd0, out_valid}, 64'd0);
      chk("str_stall", {48'd0, stall_count}, 64'd0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA;
      step();
      in_data = 64'hB;
      step();
      chk("bp_occ", {62'd0, occupancy}, 64'd2);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_data", out_data, 64'hA);
      chk("bp_stall1", {48'd0, stall_count}, 64'd1);
      in_valid = 1'b0;
      in_data  = 64'hEE;
      step();
      chk("bp_stall2", {48'd0, stall_count}, 64'd2);
      chk("bp_hold_data", out_data, 64'hA);
      step();
      chk("bp_stall3", {48'd0, stall_count}, 64'd3);
      out_ready = 1'b1;
      step();
      chk("bp_drain_b", out_data, 64'hB);
      chk("bp_occ1", {62'd0, occupancy}, 64'd1);
      chk("bp_in_ready1", {63'd0, in_ready}, 64'd1);
      chk("bp_stall_keep", {48'd0, stall_count}, 64'd3);
      step();
      chk("bp_empty", {63'd0, out_valid}, 64'd0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA;
      step();
      in_data = 64'hB;
      step();
      chk("fl_full", {62'd0, occupancy}, 64'd2);
      chk("fl_stall_pre", {48'd0, stall_count}, 64'd4);
      flush     = 1'b1;
      in_data   = 64'hC;
      out_ready = 1'b1;
      step();
      chk("fl_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_occ", {62'd0, occupancy}, 64'd0);
      chk("fl_data", out_data, 64'd0);
      chk("fl_stall", {48'd0, stall_count}, 64'd4);
      flush    = 1'b0;
      in_valid = 1'b0;
      step();
      chk("fl_no_c", {63'd0, out_valid}, 64'd0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h5;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      chk("sat_reach", {61'd0, s_stall_count}, 64'd7);
      chk("sat_wide7", {48'd0, stall_count}, 64'd7);
      repeat (7) step();
      chk("sat_hold", {61'd0, s_stall_count}, 64'd7);
      chk("sat_wide14", {48'd0, stall_count}, 64'd14);
      chk("sat_data", out_data, 64'h5);

      in_valid = 1'b1;
      in_data  = 64'h6;
      step();
      chk("ar_full", {62'd0, occupancy}, 64'd2);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("ar_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
      chk("ar_occ", {62'd0, occupancy}, 64'd0);
      chk("ar_data", out_data, 64'd0);
      chk("ar_stall", {48'd0, stall_count}, 64'd0);
      chk("ar_sat_stall", {61'd0, s_stall_count}, 64'd0);
      #1;
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'h7;
      out_ready = 1'b1;
      step();
      chk("ar_resume_data", out_data, 64'h7);
      chk("ar_resume_valid", {63'd0, out_valid}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
